i2s_echo_delay: RTL

- Downstream stage of the I2S receiver. Consumes its parallel left/right sample outputs and its word-select line, all in the mclk domain.
- Detects each new stereo frame and applies a feedback echo: y = x + gain·y[n−delay].
- Delivers the processed samples with a one-cycle valid strobe to the I2S transmitter / effect chain.
- Delay line is an inferred single-port synchronous RAM holding one stereo word per frame.

---
 rtl/i2s_echo_delay.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_echo_delay.sv
// ---------------------------------------------------------------------------
// i2s_echo_delay
//
// Feedback echo stage placed after the I2S receiver. Once per stereo frame
// (rising edge of ws) it captures the left/right samples, reads the delayed
// output word from a single-port delay-line RAM, and computes
//     y = sat( x + ((y[n - delay] * gain) >>> 8) )
// per channel. It then writes y back into the delay line and presents y with a
// one-cycle valid strobe.
//
// Ports
//   mclk       master clock, all logic on the rising edge
//   reset_n    asynchronous reset, active HIGH (legacy name)
//   ws         word select from the receiver (mclk domain)
//   l_in/r_in  signed left/right samples from the receiver
//   enable     1 = echo applied, 0 = bypass (y = x, still written to the line)
//   delay      echo delay in frames, 0 selects the full DEPTH
//   gain       unsigned feedback gain, scale gain/256
//   l_out/r_out signed processed samples, held between updates
//   out_valid  one-cycle pulse when l_out/r_out update
//   busy       high while a frame is being processed
// ---------------------------------------------------------------------------
module i2s_echo_delay #(
    parameter int D_WIDTH = 24,
    parameter int ADDR_W  = 12
) (
    input  logic                      mclk,
    input  logic                      reset_n,
    input  logic                      ws,
    input  logic signed [D_WIDTH-1:0] l_in,
    input  logic signed [D_WIDTH-1:0] r_in,
    input  logic                      enable,
    input  logic        [ADDR_W-1:0]  delay,
    input  logic        [7:0]         gain,
    output logic signed [D_WIDTH-1:0] l_out,
    output logic signed [D_WIDTH-1:0] r_out,
    output logic                      out_valid,
    output logic                      busy
);

    localparam int DEPTH = 1 << ADDR_W;

    // Wide enough for x + (d * 255) >>> 8 with headroom, so the sum can be
    // compared against the sample range before truncation.
    localparam int SW = D_WIDTH + 10;

    // The full-depth value needs one bit more than a RAM address.
    localparam logic [ADDR_W:0] FILL_FULL = {1'b1, {ADDR_W{1'b0}}};

    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_MIX,
        S_WR
    } state_t;

    state_t state;
    state_t state_nx;

    // Frame detection and pointers
    logic              ws_q;
    logic              capture;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   fill;

    // Per-frame captured operands
    logic signed [D_WIDTH-1:0] x_l;
    logic signed [D_WIDTH-1:0] x_r;
    logic        [ADDR_W:0]    d_eff;
    logic                      en_r;
    logic        [7:0]         g_r;

    // Mixer results, written to the line and the outputs in WR
    logic signed [D_WIDTH-1:0] y_l;
    logic signed [D_WIDTH-1:0] y_r;
    logic signed [D_WIDTH-1:0] d_l;
    logic signed [D_WIDTH-1:0] d_r;
    logic signed [D_WIDTH-1:0] mix_l;
    logic signed [D_WIDTH-1:0] mix_r;

    // Delay-line RAM port
    logic                   ram_re;
    logic                   ram_we;
    logic [ADDR_W-1:0]      rd_addr;
    logic [ADDR_W-1:0]      ram_addr;
    logic [2*D_WIDTH-1:0]   rdata;
    logic [2*D_WIDTH-1:0]   mem [DEPTH];

    // -----------------------------------------------------------------------
    // Saturating echo mix for one channel. The product is signed x unsigned
    // gain (zero-extended), and >>> rounds toward minus infinity.
    // -----------------------------------------------------------------------
    function automatic logic signed [D_WIDTH-1:0] echo_sat(
        input logic signed [D_WIDTH-1:0] x,
        input logic signed [D_WIDTH-1:0] d,
        input logic        [7:0]         g
    );
        logic signed [SW-1:0] x_w;
        logic signed [SW-1:0] d_w;
        logic signed [SW-1:0] g_w;
        logic signed [SW-1:0] prod;
        logic signed [SW-1:0] sum;
        x_w  = {{(SW-D_WIDTH){x[D_WIDTH-1]}}, x};
        d_w  = {{(SW-D_WIDTH){d[D_WIDTH-1]}}, d};
        g_w  = {{(SW-8){1'b0}}, g};
        prod = d_w * g_w;
        sum  = x_w + (prod >>> 8);
        if (sum > SAT_MAX) begin
            return SAT_MAX[D_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            return SAT_MIN[D_WIDTH-1:0];
        end
        return sum[D_WIDTH-1:0];
    endfunction

    // A new frame is accepted only from IDLE; an edge arriving mid-frame is
    // dropped rather than queued.
    assign capture = ws && !ws_q && (state == S_IDLE);

    assign busy = (state != S_IDLE);

    // -----------------------------------------------------------------------
    // FSM next state and RAM strobes
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        case (state)
            S_IDLE: if (capture) state_nx = S_RD;
            S_RD: begin
                ram_re   = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: state_nx = S_MIX;
            S_MIX:  state_nx = S_WR;
            S_WR: begin
                ram_we   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // d_eff mod DEPTH is just its low bits, so DEPTH itself reads wr_ptr:
    // the oldest word, about to be overwritten in WR.
    assign rd_addr  = wr_ptr - d_eff[ADDR_W-1:0];
    assign ram_addr = ram_we ? wr_ptr : rd_addr;

    // -----------------------------------------------------------------------
    // Control registers (asynchronous, active-high reset)
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge mclk or posedge reset_n) begin
        if (reset_n) begin
            state     <= S_IDLE;
            ws_q      <= 1'b0;
            wr_ptr    <= '0;
            fill      <= '0;
            l_out     <= '0;
            r_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            ws_q      <= ws;
            out_valid <= 1'b0;
            if (state == S_WR) begin
                wr_ptr    <= wr_ptr + ADDR_W'(1);
                if (fill != FILL_FULL) begin
                    fill <= fill + (ADDR_W+1)'(1);
                end
                l_out     <= y_l;
                r_out     <= y_r;
                out_valid <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers. These are always loaded before use in a frame, so
    // they carry no reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (capture) begin
            x_l   <= l_in;
            x_r   <= r_in;
            d_eff <= (delay == '0) ? FILL_FULL : {1'b0, delay};
            en_r  <= enable;
            g_r   <= gain;
        end
        if (state == S_MIX) begin
            y_l <= mix_l;
            y_r <= mix_r;
        end
    end

    // -----------------------------------------------------------------------
    // Mixer. Words older than the history written since reset are treated as
    // silence, which masks whatever the RAM held before.
    // -----------------------------------------------------------------------
    always_comb begin
        d_l = '0;
        d_r = '0;
        if (fill >= d_eff) begin
            d_l = rdata[2*D_WIDTH-1 -: D_WIDTH];
            d_r = rdata[D_WIDTH-1:0];
        end
        mix_l = en_r ? echo_sat(x_l, d_l, g_r) : x_l;
        mix_r = en_r ? echo_sat(x_r, d_r, g_r) : x_r;
    end

    // -----------------------------------------------------------------------
    // Single-port delay-line RAM, left sample in the upper half. Read and
    // write are mutually exclusive by construction of the FSM; an aborted
    // frame never reaches WR, so it never writes.
    // -----------------------------------------------------------------------
    // NOTE: the memory array has no reset so it maps onto block RAM; stale
    // contents are masked by the fill counter instead.
    always_ff @(posedge mclk) begin
        if (ram_we) begin
            mem[ram_addr] <= {y_l, y_r};
        end else if (ram_re) begin
            rdata <= mem[ram_addr];
        end
    end

endmodule
